// File: rtl/fetch_flow_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_flow_ctrl
//
// Purpose:
//   Fetch-side flow controller that sits between the ID stage, the hazard
//   information coming back from EX, the debug unit and the PC controller.
//   It does four things:
//     * detects load-use and branch-on-EX-result hazards and stalls fetch
//       while bubbling ID/EX,
//     * redirects fetch on jumps and taken branches (with an IF/ID flush),
//     * decodes HALT, lets the older instructions drain through EX/MEM/WB,
//       then parks the machine with o_halted raised,
//     * implements debug run / single-step control of the whole pipeline.
//
// Parameters:
//   ADDR_W        width of jump / branch target addresses
//   DRAIN_CYCLES  cycles the pipeline keeps running after HALT is decoded
//
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_run, i_step         debug free-run level and single-step pulse
//   i_id_*                decode information for the instruction in ID
//   i_ex_*                destination / type of the instruction in EX
//   o_jump, o_jump_addr   redirect request to the PC controller
//   o_stall               hold PC and IF/ID
//   o_halt                freeze the PC
//   o_if_id_flush         turn IF/ID into a NOP at the next edge
//   o_id_ex_bubble        insert a NOP into ID/EX at the next edge
//   o_pipe_en             global enable for all pipeline registers
//   o_halted              program finished and pipeline drained
// -----------------------------------------------------------------------------
module fetch_flow_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_step,
    input  logic [4:0]        i_id_rs,
    input  logic [4:0]        i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_id_is_branch,
    input  logic              i_id_br_taken,
    input  logic [ADDR_W-1:0] i_id_br_target,
    input  logic              i_id_is_jump,
    input  logic [ADDR_W-1:0] i_id_jmp_target,
    input  logic              i_id_is_halt,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_reg_write,
    input  logic [4:0]        i_ex_rd,
    output logic              o_jump,
    output logic [ADDR_W-1:0] o_jump_addr,
    output logic              o_stall,
    output logic              o_halt,
    output logic              o_if_id_flush,
    output logic              o_id_ex_bubble,
    output logic              o_pipe_en,
    output logic              o_halted
);

    // Guard against a zero-width counter if someone sets DRAIN_CYCLES to 0.
    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DRAIN_CYCLES < 1) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PAUSE = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;

    // -------------------------------------------------------------------------
    // Source-register match against the EX destination.
    // Index 0 is rs, index 1 is rt.
    // -------------------------------------------------------------------------
    logic [4:0] src_reg [2];
    logic [1:0] src_match;

    assign src_reg[0] = i_id_rs;
    assign src_reg[1] = i_id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
            assign src_match[gi] = (i_ex_rd == src_reg[gi]);
        end
    endgenerate

    // r0 is hard-wired to zero, so a write to it never creates a dependency.
    logic ex_rd_nonzero;
    assign ex_rd_nonzero = (i_ex_rd != 5'd0);

    // Load-use only counts rt when the instruction actually reads rt, but a
    // branch always compares both operands in ID, so it depends on both.
    logic load_use;
    logic branch_dep;
    logic redirect;

    assign load_use   = i_ex_mem_read && ex_rd_nonzero &&
                        (src_match[0] || (i_id_uses_rt && src_match[1]));
    assign branch_dep = i_id_is_branch && i_ex_reg_write && ex_rd_nonzero &&
                        (src_match[0] || src_match[1]);
    assign redirect   = i_id_is_jump || (i_id_is_branch && i_id_br_taken);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_PAUSE;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;

        o_jump         = 1'b0;
        o_jump_addr    = '0;
        o_stall        = 1'b0;
        o_halt         = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pipe_en      = 1'b0;
        o_halted       = 1'b0;

        unique case (state_reg)
            ST_PAUSE: begin
                o_halt = 1'b1;
                if (i_run) begin
                    state_next = ST_RUN;
                end else if (i_step) begin
                    state_next = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                o_pipe_en = 1'b1;

                // A single step always returns to PAUSE, even when the cycle
                // it granted was spent stalling. HALT below overrides this.
                if (state_reg == ST_STEP) begin
                    state_next = ST_PAUSE;
                end else if (!i_run) begin
                    state_next = ST_PAUSE;
                end

                // Hazard decode, highest priority first. A stalled HALT stays
                // in ID and is recognised once the hazard clears.
                if (load_use || branch_dep) begin
                    o_stall        = 1'b1;
                    o_id_ex_bubble = 1'b1;
                end else if (i_id_is_halt) begin
                    o_halt         = 1'b1;
                    o_if_id_flush  = 1'b1;
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end else if (redirect) begin
                    o_jump        = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_jump_addr   = i_id_is_jump ? i_id_jmp_target
                                                 : i_id_br_target;
                end
            end

            ST_DRAIN: begin
                // Older instructions retire; anything fetched behind HALT is
                // squashed every cycle and no redirect or stall is honoured.
                o_pipe_en     = 1'b1;
                o_halt        = 1'b1;
                o_if_id_flush = 1'b1;
                if (drain_cnt_reg >= CNT_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                o_halt   = 1'b1;
                o_halted = 1'b1;
            end

            default: begin
                state_next     = ST_PAUSE;
                drain_cnt_next = '0;
                o_halt         = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_flow_ctrl
//
// Directed bench for fetch_flow_ctrl. The stimulus process drives inputs just
// after each rising edge and pushes the hand-computed output vector for that
// cycle into a scoreboard queue. A separate monitor samples the DUT on every
// falling edge, pops the oldest expectation and compares.
// -----------------------------------------------------------------------------
module tb_fetch_flow_ctrl;

    localparam int ADDR_W = 32;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_run;
    logic              i_step;
    logic [4:0]        i_id_rs;
    logic [4:0]        i_id_rt;
    logic              i_id_uses_rt;
    logic              i_id_is_branch;
    logic              i_id_br_taken;
    logic [ADDR_W-1:0] i_id_br_target;
    logic              i_id_is_jump;
    logic [ADDR_W-1:0] i_id_jmp_target;
    logic              i_id_is_halt;
    logic              i_ex_mem_read;
    logic              i_ex_reg_write;
    logic [4:0]        i_ex_rd;
    logic              o_jump;
    logic [ADDR_W-1:0] o_jump_addr;
    logic              o_stall;
    logic              o_halt;
    logic              o_if_id_flush;
    logic              o_id_ex_bubble;
    logic              o_pipe_en;
    logic              o_halted;

    fetch_flow_ctrl #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(3)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_run           (i_run),
        .i_step          (i_step),
        .i_id_rs         (i_id_rs),
        .i_id_rt         (i_id_rt),
        .i_id_uses_rt    (i_id_uses_rt),
        .i_id_is_branch  (i_id_is_branch),
        .i_id_br_taken   (i_id_br_taken),
        .i_id_br_target  (i_id_br_target),
        .i_id_is_jump    (i_id_is_jump),
        .i_id_jmp_target (i_id_jmp_target),
        .i_id_is_halt    (i_id_is_halt),
        .i_ex_mem_read   (i_ex_mem_read),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_ex_rd         (i_ex_rd),
        .o_jump          (o_jump),
        .o_jump_addr     (o_jump_addr),
        .o_stall         (o_stall),
        .o_halt          (o_halt),
        .o_if_id_flush   (o_if_id_flush),
        .o_id_ex_bubble  (o_id_ex_bubble),
        .o_pipe_en       (o_pipe_en),
        .o_halted        (o_halted)
    );

    always #5 i_clk = ~i_clk;

    // Packed vector: {jump, addr[31:0], stall, halt, flush, bubble, pipe_en, halted}
    logic [38:0] exp_q  [$];
    string       name_q [$];
    int          checks = 0;
    int          errors = 0;

    logic [38:0] act_vec;
    assign act_vec = {o_jump, o_jump_addr, o_stall, o_halt, o_if_id_flush,
                      o_id_ex_bubble, o_pipe_en, o_halted};

    // Monitor: the DUT presents a full output vector every cycle.
    always @(negedge i_clk) begin
        logic [38:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act_vec !== e) begin
                errors++;
                $display("FAIL %s: got j=%b a=%h st=%b h=%b fl=%b bu=%b pe=%b hd=%b, want j=%b a=%h st=%b h=%b fl=%b bu=%b pe=%b hd=%b",
                         n, act_vec[38], act_vec[37:6], act_vec[5], act_vec[4],
                         act_vec[3], act_vec[2], act_vec[1], act_vec[0],
                         e[38], e[37:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end else begin
                $display("check %-18s ok  j=%b a=%h st=%b h=%b fl=%b bu=%b pe=%b hd=%b",
                         n, e[38], e[37:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one clock.
    task automatic expect_cyc(input string n, input bit j, input logic [31:0] a,
                              input bit st, input bit h, input bit fl,
                              input bit bu, input bit pe, input bit hd);
        exp_q.push_back({j, a, st, h, fl, bu, pe, hd});
        name_q.push_back(n);
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_id_ex();
        i_id_rs         = 5'd0;
        i_id_rt         = 5'd0;
        i_id_uses_rt    = 1'b0;
        i_id_is_branch  = 1'b0;
        i_id_br_taken   = 1'b0;
        i_id_br_target  = '0;
        i_id_is_jump    = 1'b0;
        i_id_jmp_target = '0;
        i_id_is_halt    = 1'b0;
        i_ex_mem_read   = 1'b0;
        i_ex_reg_write  = 1'b0;
        i_ex_rd         = 5'd0;
    endtask

    // Shorthands for the common output vectors.
    task automatic e_pause(input string n); expect_cyc(n, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic e_run  (input string n); expect_cyc(n, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic e_stall(input string n); expect_cyc(n, 0, 0, 1, 0, 0, 1, 1, 0); endtask
    task automatic e_drain(input string n); expect_cyc(n, 0, 0, 0, 1, 1, 0, 1, 0); endtask
    task automatic e_done (input string n); expect_cyc(n, 0, 0, 0, 1, 0, 0, 0, 1); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_run   = 1'b0;
        i_step  = 1'b0;
        clr_id_ex();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Reset state and entry into RUN
        e_pause("rst_pause");
        i_run = 1'b1;
        e_pause("pause_to_run");
        e_run("run_idle");

        // Load-use and r0 boundary
        i_ex_mem_read = 1; i_ex_rd = 5; i_id_rs = 5;
        e_stall("load_use_rs");
        i_ex_rd = 0; i_id_rs = 0;
        e_run("load_use_r0");
        clr_id_ex();

        // Jump redirect
        i_id_is_jump = 1; i_id_jmp_target = 32'h40;
        expect_cyc("jump_0x40", 1, 32'h40, 0, 0, 1, 0, 1, 0);
        clr_id_ex();

        // Taken branch loses to load-use on rt
        i_id_is_branch = 1; i_id_br_taken = 1; i_id_br_target = 32'h80;
        i_id_rs = 3; i_id_rt = 7; i_id_uses_rt = 1;
        i_ex_mem_read = 1; i_ex_rd = 7;
        e_stall("br_taken_lu_rt");
        clr_id_ex();

        // Branch depending on an ALU result in EX (rs, then rt without uses_rt)
        i_id_is_branch = 1; i_id_br_taken = 1; i_id_br_target = 32'h80;
        i_id_rs = 3; i_ex_reg_write = 1; i_ex_rd = 3;
        e_stall("br_dep_rs");
        clr_id_ex();
        i_id_is_branch = 1; i_id_rt = 9; i_id_rs = 1;
        i_ex_reg_write = 1; i_ex_rd = 9;
        e_stall("br_dep_rt");
        clr_id_ex();

        // Non-hazards
        i_ex_mem_read = 1; i_ex_rd = 9; i_id_rt = 9; i_id_rs = 1;
        e_run("lu_rt_not_used");
        clr_id_ex();
        i_ex_reg_write = 1; i_ex_rd = 4; i_id_rs = 4;
        e_run("regwr_no_branch");
        clr_id_ex();

        // Branch redirect, not-taken, and jump/branch priority
        i_id_is_branch = 1; i_id_br_taken = 1; i_id_br_target = 32'h80;
        expect_cyc("br_taken_0x80", 1, 32'h80, 0, 0, 1, 0, 1, 0);
        i_id_br_taken = 0;
        e_run("br_not_taken");
        i_id_br_taken = 1; i_id_br_target = 32'h88;
        i_id_is_jump = 1; i_id_jmp_target = 32'h44;
        expect_cyc("jump_beats_br", 1, 32'h44, 0, 0, 1, 0, 1, 0);
        clr_id_ex();

        // HALT behind a load-use is held off
        i_id_is_halt = 1; i_ex_mem_read = 1; i_ex_rd = 2; i_id_rs = 2;
        e_stall("halt_lu_prio");
        clr_id_ex();

        // Step ignored in RUN, then drop run
        i_step = 1;
        e_run("step_in_run");
        e_run("step_in_run2");
        i_step = 0; i_run = 0;
        e_run("run_drop");
        e_pause("paused");

        // Single step
        i_step = 1;
        e_pause("step_req");
        i_step = 0;
        e_run("step_cycle");
        e_pause("step_back");

        // Step consumed by a stall
        i_step = 1;
        e_pause("step_req2");
        i_step = 0; i_ex_mem_read = 1; i_ex_rd = 6; i_id_rs = 6;
        e_stall("step_stall");
        clr_id_ex();
        e_pause("step_after_stall");

        // HALT during a step drains without run, ignoring redirects/hazards
        i_step = 1;
        e_pause("step_req3");
        i_step = 0; i_id_is_halt = 1; i_id_is_jump = 1; i_id_jmp_target = 32'h40;
        expect_cyc("step_halt", 0, 0, 0, 1, 1, 0, 1, 0);
        clr_id_ex();
        i_id_is_jump = 1; i_id_jmp_target = 32'h40;
        i_ex_mem_read = 1; i_ex_rd = 5; i_id_rs = 5; i_run = 1; i_step = 1;
        e_drain("drain0");
        e_drain("drain1");
        e_drain("drain2");
        clr_id_ex();
        i_step = 0;
        e_done("done0");
        i_run = 0;
        e_done("done1");
        i_run = 1;
        e_done("done2");
        i_step = 1;
        e_done("done3");
        i_step = 0; i_run = 0;

        // Reset in DONE
        i_reset = 1;
        e_done("rst_in_done");
        i_reset = 0;
        e_pause("after_rst_done");

        // Reset in RUN overrides i_run
        i_run = 1;
        e_pause("to_run2");
        e_run("run2");
        i_reset = 1;
        e_run("rst_in_run");
        i_reset = 0;
        e_pause("after_rst_run");
        e_run("run3");

        // HALT in RUN, reset mid-drain
        i_id_is_halt = 1;
        expect_cyc("run_halt", 0, 0, 0, 1, 1, 0, 1, 0);
        clr_id_ex();
        e_drain("drain_a0");
        e_drain("drain_a1");
        i_reset = 1;
        e_drain("rst_in_drain");
        i_reset = 0;
        e_pause("after_rst_drain");
        e_run("run4");

        // Full drain from RUN with i_run toggling
        i_id_is_halt = 1;
        expect_cyc("run_halt2", 0, 0, 0, 1, 1, 0, 1, 0);
        clr_id_ex();
        i_run = 0;
        e_drain("drain_b0");
        i_run = 1;
        e_drain("drain_b1");
        i_run = 0;
        e_drain("drain_b2");
        e_done("done_b0");
        i_run = 1;
        e_done("done_b1");
        i_run = 0;

        // Reset in DONE again, then reset in STEP and PAUSE
        i_reset = 1;
        e_done("rst_in_done2");
        i_reset = 0;
        e_pause("after_rst_done2");
        i_step = 1;
        e_pause("s_req");
        i_step = 0; i_reset = 1;
        e_run("rst_in_step");
        i_reset = 0;
        e_pause("after_rst_step");
        i_reset = 1;
        e_pause("rst_in_pause");
        i_reset = 0;
        e_pause("after_rst_pause");

        @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
